// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned REGION_W = 4;

  // Transaction sequencer states (3-bit encoding).
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WR    = 3'd2,
    ST_MERGE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin picker; remembers the last winner so a tie
// always goes to the other master.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic rr_last_q;
  logic rr_last_d;

  // Pick a winner; on a tie prefer the master that did not win last time.
  always_comb begin
    grant_o   = 2'b00;
    rr_last_d = rr_last_q;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = rr_last_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
    if (advance_i && (|grant_o)) begin
      rr_last_d = grant_o[1];
    end
  end

  // Last-winner register; resets to master 1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: round-robin between core (m0) and debug/DMA (m1),
// sequencing loads, full stores and locked read-modify-write partial stores.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned         ADDR_W     = 32,
  parameter int unsigned         DATA_W     = 32,
  parameter logic [REGION_W-1:0] RAM_REGION = 4'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_gnt_o,
  output logic                m0_rsp_valid_o,
  output logic                m0_rsp_err_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_gnt_o,
  output logic                m1_rsp_valid_o,
  output logic                m1_rsp_err_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                core_hold_o
);

  localparam int unsigned BE_W = DATA_W / BYTE_W;

  state_e              state_q, state_d;
  logic                id_q;
  logic                we_q;
  logic                err_q;
  logic [ADDR_W-3:0]   word_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [1:0]          grant;
  logic                advance;
  logic                sel_id;
  logic                sel_we;
  logic                sel_err;
  logic [ADDR_W-1:0]   sel_addr;
  logic [BE_W-1:0]     sel_be;
  logic [DATA_W-1:0]   sel_wdata;
  logic [ADDR_W-1:0]   word_addr;
  logic [DATA_W-1:0]   merged_data;
  logic                unused_addr_lsb;

  // Requests only count in IDLE and never while reset is held, so a grant
  // can never be issued for a transaction that reset would discard.
  assign advance = (state_q == ST_IDLE) && (m0_req_i || m1_req_i) && rst_n;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     ({m1_req_i, m0_req_i}),
    .advance_i (advance),
    .grant_o   (grant)
  );

  assign sel_id    = grant[1];
  assign sel_we    = sel_id ? m1_we_i    : m0_we_i;
  assign sel_addr  = sel_id ? m1_addr_i  : m0_addr_i;
  assign sel_be    = sel_id ? m1_be_i    : m0_be_i;
  assign sel_wdata = sel_id ? m1_wdata_i : m0_wdata_i;
  assign sel_err   = (sel_addr[ADDR_W-1 -: REGION_W] != RAM_REGION);

  // The RAM is word-addressed; the byte offset is carried by the enables.
  assign word_addr       = {word_q, 2'b00};
  assign unused_addr_lsb = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

  // Byte lanes for the write half of a read-modify-write.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    assign merged_data[gi*BYTE_W +: BYTE_W] = be_q[gi] ? wdata_q[gi*BYTE_W +: BYTE_W]
                                                       : mem_rdata_i[gi*BYTE_W +: BYTE_W];
  end

  // Capture the winning request's attributes at grant time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      word_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (advance) begin
      id_q    <= sel_id;
      we_q    <= sel_we;
      err_q   <= sel_err;
      word_q  <= sel_addr[ADDR_W-1:2];
      be_q    <= sel_be;
      wdata_q <= sel_wdata;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and all handshake / RAM outputs decoded from the current state.
  always_comb begin
    state_d        = state_q;
    m0_gnt_o       = 1'b0;
    m1_gnt_o       = 1'b0;
    m0_rsp_valid_o = 1'b0;
    m1_rsp_valid_o = 1'b0;
    m0_rsp_err_o   = 1'b0;
    m1_rsp_err_o   = 1'b0;
    m0_rdata_o     = '0;
    m1_rdata_o     = '0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    case (state_q)
      ST_IDLE: begin
        if (advance) begin
          m0_gnt_o = grant[0];
          m1_gnt_o = grant[1];
          if (sel_err) begin
            state_d = ST_RESP;
          end else if (!sel_we || !(&sel_be)) begin
            state_d = ST_RD;
          end else begin
            state_d = ST_WR;
          end
        end
      end
      ST_RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = word_addr;
        state_d    = we_q ? ST_MERGE : ST_RESP;
      end
      ST_MERGE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = word_addr;
        mem_wdata_o = merged_data;
        state_d     = ST_RESP;
      end
      ST_WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = word_addr;
        mem_wdata_o = wdata_q;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (id_q) begin
          m1_rsp_valid_o = 1'b1;
          m1_rsp_err_o   = err_q;
          m1_rdata_o     = (!we_q && !err_q) ? mem_rdata_i : '0;
        end else begin
          m0_rsp_valid_o = 1'b1;
          m0_rsp_err_o   = err_q;
          m0_rdata_o     = (!we_q && !err_q) ? mem_rdata_i : '0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign core_hold_o = m0_req_i & ~m0_rsp_valid_o;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter with a 64-word RAM model
// and a word-level reference memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic        m0_gnt_o, m0_rsp_valid_o, m0_rsp_err_o;
  logic        m1_gnt_o, m1_rsp_valid_o, m1_rsp_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        mem_req_o, mem_we_o, core_hold_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ram   [64];
  logic [31:0] ref_m [64];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  logic [3:0]  be_tab [10] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'h7, 4'hE, 4'hF};

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_be_i(m0_be_i),
    .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rsp_valid_o(m0_rsp_valid_o),
    .m0_rsp_err_o(m0_rsp_err_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_be_i(m1_be_i),
    .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rsp_valid_o(m1_rsp_valid_o),
    .m1_rsp_err_o(m1_rsp_err_o), .m1_rdata_o(m1_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .core_hold_o(core_hold_o)
  );

  always #5 clk = ~clk;

  // RAM model: read data one cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    if (mem_req_o && !mem_we_o) mem_rdata_i <= ram[mem_addr_o[7:2]];
    else                        mem_rdata_i <= $urandom;
    if (mem_req_o && mem_we_o)  ram[mem_addr_o[7:2]] <= mem_wdata_o;
    if (poke_en)                ram[poke_idx] <= poke_val;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = val;
    ref_m[idx] = val;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    if (m == 0) begin
      m0_req_i = req; m0_we_i = we; m0_addr_i = addr; m0_be_i = be; m0_wdata_i = wd;
    end else begin
      m1_req_i = req; m1_we_i = we; m1_addr_i = addr; m1_be_i = be; m1_wdata_i = wd;
    end
  endtask

  function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  function automatic logic gnt_of(input int m);
    return (m == 0) ? m0_gnt_o : m1_gnt_o;
  endfunction
  function automatic logic rsp_of(input int m);
    return (m == 0) ? m0_rsp_valid_o : m1_rsp_valid_o;
  endfunction
  function automatic logic err_of(input int m);
    return (m == 0) ? m0_rsp_err_o : m1_rsp_err_o;
  endfunction
  function automatic logic [31:0] rdata_of(input int m);
    return (m == 0) ? m0_rdata_o : m1_rdata_o;
  endfunction

  // One transaction from a single master with the other idle. Expected
  // timing: error 1 cycle, load/full store 2, partial store 3.
  task automatic run_txn(input int m, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
    logic        err, part, e_req, e_we;
    int          lat;
    logic [5:0]  idx;
    logic [31:0] exp_w, exp_rd, waddr;
    err    = (addr[31:28] != 4'h0);
    part   = we && (be != 4'hF);
    idx    = addr[7:2];
    waddr  = {addr[31:2], 2'b00};
    lat    = err ? 1 : (part ? 3 : 2);
    exp_w  = merge_word(ref_m[idx], wd, we ? be : 4'h0);
    exp_rd = (!we && !err) ? ref_m[idx] : 32'h0;
    drive(m, 1'b1, we, addr, be, wd);
    #1;
    chk1("gnt_c0", gnt_of(m), 1'b1);
    chk1("gnt_other_c0", gnt_of(1 - m), 1'b0);
    chk1("memreq_c0", mem_req_o, 1'b0);
    if (m == 0) chk1("hold_c0", core_hold_o, 1'b1);
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk);
      #1;
      if (m == 1 && c == 1) m1_req_i = 1'b0;
      if (c == lat + 1) m0_req_i = 1'b0;
      #1;
      e_req = !err && (c == 1 || (part && c == 2));
      e_we  = e_req && we && (part ? (c == 2) : 1'b1);
      chk1($sformatf("memreq_c%0d", c), mem_req_o, e_req);
      chk1($sformatf("memwe_c%0d", c), mem_we_o, e_we);
      if (e_req) chk("memaddr", mem_addr_o, waddr);
      if (e_we)  chk("memwdata", mem_wdata_o, exp_w);
      chk1("gnt_quiet", m0_gnt_o | m1_gnt_o, 1'b0);
      chk1($sformatf("rsp_valid_c%0d", c), rsp_of(m), c == lat);
      chk1("rsp_other", rsp_of(1 - m), 1'b0);
      if (c == lat) begin
        chk1("rsp_err", err_of(m), err);
        chk("rdata", rdata_of(m), exp_rd);
      end
      if (m == 0) chk1($sformatf("hold_c%0d", c), core_hold_o, c < lat);
    end
    if (we && !err) ref_m[idx] = exp_w;
    chk("ram_word", ram[idx], ref_m[idx]);
    $display("txn m%0d we=%0d addr=%h be=%h wd=%h lat=%0d", m, we, addr, be, wd, lat);
  endtask

  initial begin
    int          m;
    logic        we;
    logic [3:0]  be, rg;
    logic [31:0] addr, wd, exp_w;

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    for (int i = 0; i < 64; i++) poke(6'(i), $urandom);

    // Reset state
    chk1("rst_memreq", mem_req_o, 1'b0);
    chk1("rst_memwe", mem_we_o, 1'b0);
    chk("rst_memaddr", mem_addr_o, 32'h0);
    chk("rst_memwdata", mem_wdata_o, 32'h0);
    chk1("rst_rsp", m0_rsp_valid_o | m1_rsp_valid_o, 1'b0);
    chk1("rst_hold", core_hold_o, 1'b0);

    // Tie from reset: m0 first, m1 next, then m0 again
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h14, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h18, 4'hF, 32'h0);
    #1;
    chk1("tie_c0_gnt0", m0_gnt_o, 1'b1);
    chk1("tie_c0_gnt1", m1_gnt_o, 1'b0);
    tick(); m0_req_i = 1'b0; #1;
    chk1("tie_c1_gnt1", m1_gnt_o, 1'b0);
    chk("tie_c1_addr", mem_addr_o, 32'h14);
    tick();
    chk1("tie_c2_rsp0", m0_rsp_valid_o, 1'b1);
    chk("tie_c2_rdata", m0_rdata_o, ref_m[5]);
    tick();
    chk1("tie_c3_gnt1", m1_gnt_o, 1'b1);
    chk1("tie_c3_gnt0", m0_gnt_o, 1'b0);
    tick(); drive(0, 1'b1, 1'b0, 32'h1C, 4'hF, 32'h0); #1;
    chk1("tie_c4_nognt", m0_gnt_o | m1_gnt_o, 1'b0);
    tick();
    chk1("tie_c5_rsp1", m1_rsp_valid_o, 1'b1);
    chk("tie_c5_rdata", m1_rdata_o, ref_m[6]);
    tick();
    chk1("tie_c6_gnt0", m0_gnt_o, 1'b1);
    chk1("tie_c6_gnt1", m1_gnt_o, 1'b0);
    tick(); m0_req_i = 1'b0; m1_req_i = 1'b0; #1;
    chk("tie_c7_addr", mem_addr_o, 32'h1C);
    tick();
    chk1("tie_c8_rsp0", m0_rsp_valid_o, 1'b1);
    chk("tie_c8_rdata", m0_rdata_o, ref_m[7]);
    tick();
    $display("txn tie sequence done");

    // Directed plan items
    poke(6'd4, 32'hDEADBEEF);
    run_txn(0, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
    poke(6'd8, 32'h11223344);
    run_txn(1, 1'b1, 32'h0000_0021, 4'b0010, 32'h0000_AB00);
    chk("pm_ram", ram[8], 32'h1122AB44);
    run_txn(0, 1'b1, 32'h1000_0000, 4'hF, 32'h5555_5555);

    // Lock: m0 requests during m1's RD/MERGE
    wd = $urandom;
    drive(1, 1'b1, 1'b1, 32'h30, 4'b1100, wd); #1;
    chk1("lk_c0_gnt1", m1_gnt_o, 1'b1);
    exp_w = merge_word(ref_m[12], wd, 4'b1100);
    tick(); m1_req_i = 1'b0; drive(0, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0); #1;
    chk1("lk_c1_req", mem_req_o, 1'b1);
    chk1("lk_c1_we", mem_we_o, 1'b0);
    chk("lk_c1_addr", mem_addr_o, 32'h30);
    chk1("lk_c1_gnt0", m0_gnt_o, 1'b0);
    tick();
    chk1("lk_c2_we", mem_we_o, 1'b1);
    chk("lk_c2_addr", mem_addr_o, 32'h30);
    chk("lk_c2_wdata", mem_wdata_o, exp_w);
    chk1("lk_c2_gnt0", m0_gnt_o, 1'b0);
    tick();
    chk1("lk_c3_rsp1", m1_rsp_valid_o, 1'b1);
    chk1("lk_c3_req", mem_req_o, 1'b0);
    chk1("lk_c3_hold", core_hold_o, 1'b1);
    ref_m[12] = exp_w;
    tick();
    chk1("lk_c4_gnt0", m0_gnt_o, 1'b1);
    chk("lk_c4_ram", ram[12], ref_m[12]);
    tick();
    chk("lk_c5_addr", mem_addr_o, 32'h40);
    tick();
    chk1("lk_c6_rsp0", m0_rsp_valid_o, 1'b1);
    chk("lk_c6_rdata", m0_rdata_o, ref_m[16]);
    tick(); m0_req_i = 1'b0;
    $display("txn lock sequence done");

    // Reset during MERGE
    wd = $urandom;
    drive(1, 1'b1, 1'b1, 32'h50, 4'b0001, wd); #1;
    chk1("rs_c0_gnt1", m1_gnt_o, 1'b1);
    exp_w = merge_word(ref_m[20], wd, 4'b0001);
    tick(); m1_req_i = 1'b0;
    tick(); rst_n = 1'b0; #1;
    chk1("rs_c2_we", mem_we_o, 1'b1);
    chk("rs_c2_wdata", mem_wdata_o, exp_w);
    tick();
    chk1("rs_c3_req", mem_req_o, 1'b0);
    chk1("rs_c3_we", mem_we_o, 1'b0);
    chk("rs_c3_addr", mem_addr_o, 32'h0);
    chk("rs_c3_wdata", mem_wdata_o, 32'h0);
    chk1("rs_c3_rsp", m0_rsp_valid_o | m1_rsp_valid_o, 1'b0);
    ref_m[20] = exp_w;
    chk("rs_ram", ram[20], ref_m[20]);
    tick();
    chk1("rs_c4_rsp", m1_rsp_valid_o, 1'b0);
    rst_n = 1'b1;
    run_txn(0, 1'b0, 32'h50, 4'hF, 32'h0);

    // Randomized single-master traffic
    for (int t = 0; t < 40; t++) begin
      m    = int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      be   = be_tab[$urandom_range(0, 9)];
      rg   = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      addr = {rg, 20'h0, 6'($urandom), 2'($urandom)};
      run_txn(m, we, addr, be, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
